hazard_controller: RTL
======================

Name: hazard_controller

Overview:
- Pipeline hazard and sequencing controller for the 5-stage RV32 core (Fetch/Decode/Execute/Memory/Writeback).
- Generates operand-forwarding selects, load-use stalls, branch/jump flushes, and whole-pipeline freeze while data memory is not ready.
- Keeps its own shadow copy of the E/M/W register-address and control fields, updated under the same stall/flush it issues, so the datapath only supplies Decode-stage fields plus a few status bits.
- Sits beside the stage modules; its outputs drive the stage pipeline-register enables and clears and the Execute-stage operand muxes.

Parameters:
- MEM_TIMEOUT, 16: maximum consecutive MEM_WAIT cycles before abort; 0 disables the timeout.
- CNT_W, 5: width of the wait counter; must hold MEM_TIMEOUT.

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- Rs1D  in  5  Decode source register 1 (InstrD[19:15])
- Rs2D  in  5  Decode source register 2 (InstrD[24:20])
- RdD  in  5  Decode destination (InstrD[11:7])
- RegWriteD  in  1  Decode instruction writes rd
- LoadD  in  1  Decode instruction is a load (ResultSrcD==01)
- MemAccD  in  1  Decode instruction is a load or store
- PCSrcE  in  1  taken branch or jump resolved in Execute
- MemReadyM  in  1  data memory has completed the access of the Memory-stage instruction
- StallF  out  1  hold PC register
- StallD  out  1  hold F/D register
- FlushD  out  1  clear F/D register to NOP
- StallE  out  1  hold D/E register
- FlushE  out  1  clear D/E register to bubble
- StallM  out  1  hold E/M register
- FlushW  out  1  clear M/W register to bubble
- ForwardAE  out  2  Execute SrcA select
- ForwardBE  out  2  Execute SrcB select
- MemErr  out  1  one-cycle pulse on memory timeout

Behaviour:
- Shadow state: E{Rs1,Rs2,Rd,RegWrite,Load,MemAcc}, M{Rd,RegWrite,MemAcc}, W{Rd,RegWrite}, FSM state, and wait counter. Reset clears all of them and sets the state to RUN.
- While RESET is high, every output is 0.
- Forward encoding: 00 = register file, 10 = ALUResultM, 01 = ResultW.
  - ForwardAE = 10 if RegWriteM and RdM!=0 and RdM==Rs1E.
  - Otherwise ForwardAE = 01 if RegWriteW and RdW!=0 and RdW==Rs1E.
  - Otherwise ForwardAE = 00.
  - M has priority over W. ForwardBE is the same function using Rs2E.
- lwStall = LoadE and RegWriteE and RdE!=0 and (RdE==Rs1D or RdE==Rs2D).
- FSM state RUN, MemReadyM=1 or no MemAccM:
  - StallF = lwStall & ~PCSrcE
  - StallD = lwStall & ~PCSrcE
  - FlushD = PCSrcE
  - FlushE = lwStall | PCSrcE
  - StallE = StallM = FlushW = 0
  - Shadows advance: E <= FlushE ? bubble : D fields (unless StallD, in which case E <= bubble), M <= E, W <= M.
- FSM RUN -> MEM_WAIT: when MemAccM and ~MemReadyM. That same cycle is a freeze cycle.
- Freeze, in MEM_WAIT or on the entry cycle above:
  - StallF = StallD = StallE = StallM = 1, FlushW = 1, all other flushes 0.
  - PCSrcE is ignored and acted on after the freeze, since E holds.
  - E and M shadows hold; W <= bubble after the instruction in W has written once.
  - Counter increments each cycle.
- MEM_WAIT -> RUN:
  - On MemReadyM=1: the freeze is released that cycle and normal RUN equations apply.
  - Or on counter==MEM_TIMEOUT-1 (MEM_TIMEOUT>0): MemErr pulses for 1 cycle, M is bubbled, and the counter clears.
- Simultaneous events:
  - Freeze > PCSrcE flush > lwStall.
  - PCSrcE together with lwStall gives flush only (no stall).
- Bubble means RegWrite=Load=MemAcc=0, Rd=0.
- x0 never forwards and never stalls.
- Reset in MEM_WAIT returns to RUN next cycle with the counter at 0.

Optional Feature:
- Macro FORWARD_EN.
- Defined: forwarding as above.
- Undefined:
  - ForwardAE = ForwardBE = 00.
  - rawStall = D source matches a nonzero Rd with RegWrite in E, M or W.
  - rawStall replaces lwStall in all equations.

Test Plan:
- add x5,x1,x2 then sub x6,x5,x3 -> at sub in E, ForwardAE=10, ForwardBE=00, no stall.
- add x5 / nop / or x7,x0,x5 -> ForwardBE=01 in E.
- lw x5,0(x1) then add x6,x5,x5 -> 1 cycle StallF=StallD=FlushE=1, then ForwardAE=ForwardBE=01.
- Load in M with MemReadyM low 3 cycles -> 3 freeze cycles, then RUN. With MEM_TIMEOUT=4 and ready never asserted, MemErr pulses on the 4th wait cycle.
- beq taken (PCSrcE=1) coinciding with lwStall condition -> FlushD=FlushE=1, StallF=StallD=0.
- Write to x0 followed by use of x0 -> forwards 00, no stall. RESET asserted mid-MEM_WAIT -> all outputs 0, then RUN.

Source files
------------

// File: rtl/hazard_controller.sv
// Hazard/sequencing controller for the 5-stage RV32 pipeline: forwarding selects, data stalls,
// branch flushes and memory-wait freeze. Define FORWARD_EN to enable operand forwarding.
module hazard_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] RdD,
  input  logic       RegWriteD,
  input  logic       LoadD,
  input  logic       MemAccD,
  input  logic       PCSrcE,
  input  logic       MemReadyM,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushD,
  output logic       StallE,
  output logic       FlushE,
  output logic       StallM,
  output logic       FlushW,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       MemErr
);

  typedef enum logic {ST_RUN = 1'b0, ST_MEM_WAIT = 1'b1} state_t;

  localparam bit               TMO_EN   = (MEM_TIMEOUT > 0);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_EN ? MEM_TIMEOUT - 1 : 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [4:0] rs1_e_q, rs1_e_d;
  logic [4:0] rs2_e_q, rs2_e_d;
  logic [4:0] rd_e_q, rd_e_d;
  logic       regwrite_e_q, regwrite_e_d;
  logic       load_e_q, load_e_d;
  logic       memacc_e_q, memacc_e_d;
  logic [4:0] rd_m_q, rd_m_d;
  logic       regwrite_m_q, regwrite_m_d;
  logic       memacc_m_q, memacc_m_d;
  logic [4:0] rd_w_q, rd_w_d;
  logic       regwrite_w_q, regwrite_w_d;

  logic       data_stall;
  logic [1:0] fwd_a, fwd_b;
  logic       freeze, timeout;
  logic       stall_f, stall_d, flush_d, stall_e, flush_e, stall_m, flush_w, mem_err;

`ifdef FORWARD_EN
  // M has priority over W: it holds the younger write to the same register.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rd_m, input logic rw_m,
                                         input logic [4:0] rd_w, input logic rw_w);
    if (rw_m && rd_m != 5'd0 && rd_m == rs) return 2'b10;
    if (rw_w && rd_w != 5'd0 && rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  assign data_stall = load_e_q & regwrite_e_q & (rd_e_q != 5'd0) &
                      ((rd_e_q == Rs1D) | (rd_e_q == Rs2D));
  assign fwd_a = fwd_sel(rs1_e_q, rd_m_q, regwrite_m_q, rd_w_q, regwrite_w_q);
  assign fwd_b = fwd_sel(rs2_e_q, rd_m_q, regwrite_m_q, rd_w_q, regwrite_w_q);
`else
  function automatic logic src_hit(input logic [4:0] rd, input logic rw,
                                   input logic [4:0] rs1, input logic [4:0] rs2);
    return rw && rd != 5'd0 && (rd == rs1 || rd == rs2);
  endfunction

  // Without forwarding, Decode waits until every older producer has written back.
  logic unused_fwd_fields;
  assign data_stall = src_hit(rd_e_q, regwrite_e_q, Rs1D, Rs2D) |
                      src_hit(rd_m_q, regwrite_m_q, Rs1D, Rs2D) |
                      src_hit(rd_w_q, regwrite_w_q, Rs1D, Rs2D);
  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
  assign unused_fwd_fields = ^{rs1_e_q, rs2_e_q, load_e_q};
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rs1_e_d      = rs1_e_q;
    rs2_e_d      = rs2_e_q;
    rd_e_d       = rd_e_q;
    regwrite_e_d = regwrite_e_q;
    load_e_d     = load_e_q;
    memacc_e_d   = memacc_e_q;
    rd_m_d       = rd_m_q;
    regwrite_m_d = regwrite_m_q;
    memacc_m_d   = memacc_m_q;
    rd_w_d       = rd_w_q;
    regwrite_w_d = regwrite_w_q;
    stall_f      = 1'b0;
    stall_d      = 1'b0;
    flush_d      = 1'b0;
    stall_e      = 1'b0;
    flush_e      = 1'b0;
    stall_m      = 1'b0;
    flush_w      = 1'b0;
    mem_err      = 1'b0;

    // In MEM_WAIT the memory instruction is still held in M, so only readiness matters.
    freeze  = (state_q == ST_MEM_WAIT) ? ~MemReadyM : (memacc_m_q & ~MemReadyM);
    timeout = freeze & TMO_EN & (cnt_q == TMO_LAST);

    if (freeze) begin
      stall_f      = 1'b1;
      stall_d      = 1'b1;
      stall_e      = 1'b1;
      stall_m      = 1'b1;
      flush_w      = 1'b1;
      mem_err      = timeout;
      rd_w_d       = 5'd0;
      regwrite_w_d = 1'b0;
      if (timeout) begin
        // Abort the stuck access: drop it from M and resume normal flow.
        state_d      = ST_RUN;
        cnt_d        = '0;
        rd_m_d       = 5'd0;
        regwrite_m_d = 1'b0;
        memacc_m_d   = 1'b0;
      end else begin
        state_d = ST_MEM_WAIT;
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end else begin
      stall_f = data_stall & ~PCSrcE;
      stall_d = data_stall & ~PCSrcE;
      flush_d = PCSrcE;
      flush_e = data_stall | PCSrcE;
      state_d = ST_RUN;
      cnt_d   = '0;

      if (flush_e || stall_d) begin
        rs1_e_d      = 5'd0;
        rs2_e_d      = 5'd0;
        rd_e_d       = 5'd0;
        regwrite_e_d = 1'b0;
        load_e_d     = 1'b0;
        memacc_e_d   = 1'b0;
      end else begin
        rs1_e_d      = Rs1D;
        rs2_e_d      = Rs2D;
        rd_e_d       = RdD;
        regwrite_e_d = RegWriteD;
        load_e_d     = LoadD;
        memacc_e_d   = MemAccD;
      end

      rd_m_d       = rd_e_q;
      regwrite_m_d = regwrite_e_q;
      memacc_m_d   = memacc_e_q;
      rd_w_d       = rd_m_q;
      regwrite_w_d = regwrite_m_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_RUN;
      cnt_q        <= '0;
      rs1_e_q      <= 5'd0;
      rs2_e_q      <= 5'd0;
      rd_e_q       <= 5'd0;
      regwrite_e_q <= 1'b0;
      load_e_q     <= 1'b0;
      memacc_e_q   <= 1'b0;
      rd_m_q       <= 5'd0;
      regwrite_m_q <= 1'b0;
      memacc_m_q   <= 1'b0;
      rd_w_q       <= 5'd0;
      regwrite_w_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rs1_e_q      <= rs1_e_d;
      rs2_e_q      <= rs2_e_d;
      rd_e_q       <= rd_e_d;
      regwrite_e_q <= regwrite_e_d;
      load_e_q     <= load_e_d;
      memacc_e_q   <= memacc_e_d;
      rd_m_q       <= rd_m_d;
      regwrite_m_q <= regwrite_m_d;
      memacc_m_q   <= memacc_m_d;
      rd_w_q       <= rd_w_d;
      regwrite_w_q <= regwrite_w_d;
    end
  end

  // Outputs are forced low while RESET is held so the stage registers see no spurious control.
  assign StallF    = stall_f & ~RESET;
  assign StallD    = stall_d & ~RESET;
  assign FlushD    = flush_d & ~RESET;
  assign StallE    = stall_e & ~RESET;
  assign FlushE    = flush_e & ~RESET;
  assign StallM    = stall_m & ~RESET;
  assign FlushW    = flush_w & ~RESET;
  assign MemErr    = mem_err & ~RESET;
  assign ForwardAE = RESET ? 2'b00 : fwd_a;
  assign ForwardBE = RESET ? 2'b00 : fwd_b;

endmodule
